pipeline_stall_controller: RTL and testbench
============================================

PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL have parameter REG_W, default 4, register-address width.
REQ-002 SHALL have parameter CNT_W, default 16, performance-counter width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum consecutive memory-wait stall cycles before abort.
REQ-004 SHALL use one clock, and reset SHALL be asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 R1_D, R2_D  in  REG_W  decode-stage source registers.
REQ-008 Use1_D, Use2_D  in  1  source register actually read.
REQ-009 Rd_E  in  REG_W  execute-stage destination register.
REQ-010 MemRead_E  in  1  execute-stage instruction is a load.
REQ-011 BranchTaken_E  in  1  execute-stage branch resolved taken.
REQ-012 MemReq_M  in  1  memory-stage instruction accesses data memory.
REQ-013 MemReady_M  in  1  data memory completes the access this cycle.
REQ-014 Stall_F, Stall_D, Stall_E, Stall_M  out  1  hold the stage register.
REQ-015 Flush_D, Flush_E, Flush_WB  out  1  load a bubble into the stage register.
REQ-016 mem_err  out  1  sticky memory-timeout flag.
REQ-017 stall_cnt, flush_cnt  out  CNT_W  saturating performance counters.

Function
REQ-018 SHALL implement FSM states RUN and MEM_WAIT; stage outputs are combinational from state and inputs.
REQ-019 Memory stall condition: MemReq_M=1 and MemReady_M=0, in either state, with no timeout this cycle.
REQ-020 On a memory stall, SHALL assert Stall_F/D/E/M=1 and Flush_WB=1, and all other flushes SHALL be 0.
REQ-021 RUN->MEM_WAIT on a memory stall; MEM_WAIT->RUN in the cycle MemReady_M=1, and that cycle SHALL be stall-free.
REQ-022 wait_cnt SHALL load 1 on RUN->MEM_WAIT and increment on each MEM_WAIT stall cycle.
REQ-023 Timeout: in MEM_WAIT, MemReady_M=0 and wait_cnt==TIMEOUT; the module SHALL deassert all stalls, assert Flush_WB=1, set mem_err, and go to RUN. The result is exactly TIMEOUT stall cycles followed by one abort cycle.
REQ-024 Branch: when there is no memory stall, no abort and BranchTaken_E=1, the module SHALL assert Flush_D=1 and Flush_E=1 and suppress the load-use stall.
REQ-025 Load-use: when there is no memory stall, no abort and no branch, and MemRead_E & ((Use1_D & R1_D==Rd_E) | (Use2_D & R2_D==Rd_E)), the module SHALL assert Stall_F=1, Stall_D=1 and Flush_E=1.
REQ-026 Priority SHALL be memory stall/abort > branch > load-use; all other outputs SHALL be 0.
REQ-027 stall_cnt SHALL increment on every cycle with Stall_F=1 and saturate at all-ones.
REQ-028 flush_cnt SHALL increment on every cycle with Flush_D=1 and saturate at all-ones.
REQ-029 mem_err SHALL remain 1 until reset.

Reset
REQ-030 rst_n=0 SHALL immediately set state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0 and flush_cnt=0.
REQ-031 During reset, all stall and flush outputs SHALL be 0, regardless of inputs.
REQ-032 Reset asserted mid-MEM_WAIT SHALL abandon the wait without setting mem_err.

Structure
REQ-033 Package pipeline_ctrl_pkg SHALL hold the state enum (RUN, MEM_WAIT) and default REG_W, CNT_W and TIMEOUT constants.
REQ-034 Sub-module sat_counter (CNT_W, inc, async active-low reset) SHALL be instantiated for stall_cnt and for flush_cnt.
REQ-035 The forwarding unit SHALL remain a separate block and SHALL NOT be instantiated here.

Verification
REQ-036 MemRead_E=1, Rd_E=1, R1_D=1, Use1_D=1 for one cycle -> Stall_F=Stall_D=Flush_E=1 for 1 cycle; stall_cnt=1.
REQ-037 Same as REQ-036 with BranchTaken_E=1 -> Flush_D=Flush_E=1, Stall_F=0; flush_cnt=1, stall_cnt=0.
REQ-038 MemReq_M=1, MemReady_M low 3 cycles then high -> all stalls and Flush_WB=1 for 3 cycles, then 0; state returns to RUN; mem_err=0.
REQ-039 TIMEOUT=4, MemReq_M=1, MemReady_M held 0 -> stalls on cycles 1-4; cycle 5 stalls=0 and Flush_WB=1; mem_err=1 thereafter.
REQ-040 Memory stall with a simultaneous taken branch and load-use -> only memory stall outputs asserted; Flush_D=0.
REQ-041 CNT_W=2, 5 consecutive load-use cycles -> stall_cnt saturates at 3; rst_n pulsed low mid-MEM_WAIT -> all outputs 0 asynchronously, state RUN.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
//   ctrl_state_e : controller FSM states
//   DEF_*        : default parameter values for the controller
package pipeline_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_e;

    localparam int DEF_REG_W   = 4;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for performance statistics.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count this cycle
//   count      : current value, sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && (count != {CNT_W{1'b1}}))
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Hazard controller for a 5-stage pipeline: memory-wait stalls with timeout
// abort, taken-branch flushes and load-use stalls, plus saturating stall and
// flush counters.
//   clk, rst_n            : clock, asynchronous active-low reset
//   R1_D/R2_D, Use1_D/2_D : decode-stage source registers and their use bits
//   Rd_E, MemRead_E       : execute-stage destination and load flag
//   BranchTaken_E         : execute-stage branch resolved taken
//   MemReq_M, MemReady_M  : memory-stage access request / completion
//   Stall_*, Flush_*      : per-stage hold / bubble controls (combinational)
//   mem_err               : sticky memory-timeout flag
//   stall_cnt, flush_cnt  : saturating performance counters
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_W   = DEF_REG_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] R1_D,
    input  logic [REG_W-1:0] R2_D,
    input  logic             Use1_D,
    input  logic             Use2_D,
    input  logic [REG_W-1:0] Rd_E,
    input  logic             MemRead_E,
    input  logic             BranchTaken_E,
    input  logic             MemReq_M,
    input  logic             MemReady_M,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Stall_E,
    output logic             Stall_M,
    output logic             Flush_D,
    output logic             Flush_E,
    output logic             Flush_WB,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WC_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    ctrl_state_e     state;
    logic [WC_W-1:0] wait_cnt;

    logic mem_pending, abort, mem_stall, branch, load_use, hazard;

    assign mem_pending = MemReq_M & ~MemReady_M;
    // Abort replaces what would have been stall cycle TIMEOUT+1.
    assign abort       = (state == MEM_WAIT) & ~MemReady_M & (wait_cnt == WC_W'(TIMEOUT));
    assign mem_stall   = mem_pending & ~abort;

    assign hazard   = MemRead_E & ((Use1_D & (R1_D == Rd_E)) | (Use2_D & (R2_D == Rd_E)));
    assign branch   = ~mem_stall & ~abort & BranchTaken_E;
    assign load_use = ~mem_stall & ~abort & ~BranchTaken_E & hazard;

    // rst_n gates every stage control so reset forces a quiet pipeline
    // independently of whatever the inputs are doing.
    assign Stall_F  = rst_n & (mem_stall | load_use);
    assign Stall_D  = rst_n & (mem_stall | load_use);
    assign Stall_E  = rst_n & mem_stall;
    assign Stall_M  = rst_n & mem_stall;
    assign Flush_D  = rst_n & branch;
    assign Flush_E  = rst_n & (branch | load_use);
    assign Flush_WB = rst_n & (mem_stall | abort);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WC_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (abort) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                        mem_err  <= 1'b1;
                    end else if (mem_stall) begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end else begin
                        // Ready arrived (or request withdrawn): resume.
                        state    <= RUN;
                        wait_cnt <= '0;
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (Stall_F),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (Flush_D),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
module tb_pipeline_stall_controller;
    import pipeline_ctrl_pkg::*;

    localparam int REG_W   = 4;
    localparam int CNT_W   = 2;
    localparam int TIMEOUT = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [REG_W-1:0] R1_D, R2_D, Rd_E;
    logic             Use1_D, Use2_D, MemRead_E, BranchTaken_E, MemReq_M, MemReady_M;
    logic             Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_WB, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [6:0]       vec;

    int checks = 0;
    int errors = 0;

    pipeline_stall_controller #(.REG_W(REG_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .R1_D(R1_D), .R2_D(R2_D), .Use1_D(Use1_D), .Use2_D(Use2_D),
        .Rd_E(Rd_E), .MemRead_E(MemRead_E), .BranchTaken_E(BranchTaken_E),
        .MemReq_M(MemReq_M), .MemReady_M(MemReady_M),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
        .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_WB(Flush_WB),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_WB}
    assign vec = {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_WB};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        R1_D = '0; R2_D = '0; Rd_E = '0;
        Use1_D = 0; Use2_D = 0; MemRead_E = 0; BranchTaken_E = 0;
        MemReq_M = 0; MemReady_M = 0;
    endtask

    task automatic set_load_use();
        MemRead_E = 1; Rd_E = 4'd1; R1_D = 4'd1; Use1_D = 1;
    endtask

    task automatic rst_pulse();
        rst_n = 0;
        #2;
        rst_n = 1;
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        // Reset with hazards on every input: controls must stay quiet.
        set_load_use();
        MemReq_M = 1;
        BranchTaken_E = 1;
        #12;
        chk("reset_vec", 32'(vec), 32'h00);
        chk("reset_stall_cnt", 32'(stall_cnt), 0);
        chk("reset_flush_cnt", 32'(flush_cnt), 0);
        chk("reset_mem_err", 32'(mem_err), 0);
        clear_inputs();
        rst_n = 1;
        cyc();
        chk("idle_vec", 32'(vec), 32'h00);

        // Load-use via R1 for one cycle.
        set_load_use();
        #1 chk("lu_vec", 32'(vec), 32'b1100010);
        cyc();
        clear_inputs();
        #1 chk("lu_after_vec", 32'(vec), 32'h00);
        chk("lu_stall_cnt", 32'(stall_cnt), 1);
        chk("lu_flush_cnt", 32'(flush_cnt), 0);

        // Load-use via R2 only; R1 matches but is not used.
        MemRead_E = 1; Rd_E = 4'd7; R1_D = 4'd7; Use1_D = 0; R2_D = 4'd7; Use2_D = 1;
        #1 chk("lu_r2_vec", 32'(vec), 32'b1100010);
        Use2_D = 0;
        #1 chk("lu_unused_vec", 32'(vec), 32'h00);
        MemRead_E = 0; Use1_D = 1; Use2_D = 1;
        #1 chk("no_load_vec", 32'(vec), 32'h00);
        clear_inputs();

        // Taken branch overrides load-use.
        rst_pulse();
        set_load_use();
        BranchTaken_E = 1;
        #1 chk("br_vec", 32'(vec), 32'b0000110);
        cyc();
        clear_inputs();
        #1 chk("br_flush_cnt", 32'(flush_cnt), 1);
        chk("br_stall_cnt", 32'(stall_cnt), 0);

        // Memory wait of 3 cycles, then ready.
        rst_pulse();
        MemReq_M = 1; MemReady_M = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("mw_vec%0d", i), 32'(vec), 32'b1111001);
            cyc();
        end
        MemReady_M = 1;
        #1 chk("mw_ready_vec", 32'(vec), 32'h00);
        cyc();
        clear_inputs();
        #1 chk("mw_state", 32'(dut.state), 32'(RUN));
        chk("mw_mem_err", 32'(mem_err), 0);
        chk("mw_stall_cnt", 32'(stall_cnt), 3);

        // Timeout: 4 stall cycles then one abort cycle.
        rst_pulse();
        MemReq_M = 1; MemReady_M = 0;
        for (int i = 1; i <= 4; i++) begin
            #1 chk($sformatf("to_vec%0d", i), 32'(vec), 32'b1111001);
            chk($sformatf("to_err%0d", i), 32'(mem_err), 0);
            cyc();
        end
        #1 chk("to_abort_vec", 32'(vec), 32'b0000001);
        cyc();
        MemReq_M = 0;
        #1 chk("to_mem_err", 32'(mem_err), 1);
        chk("to_after_vec", 32'(vec), 32'h00);
        cyc();
        #1 chk("to_mem_err_sticky", 32'(mem_err), 1);
        chk("to_state", 32'(dut.state), 32'(RUN));

        // Memory stall outranks branch and load-use; then ready exit lets branch through.
        rst_pulse();
        chk("prio_err_clear", 32'(mem_err), 0);
        set_load_use();
        BranchTaken_E = 1; MemReq_M = 1; MemReady_M = 0;
        #1 chk("prio_vec", 32'(vec), 32'b1111001);
        chk("prio_flush_d", 32'(Flush_D), 0);
        cyc();
        MemReady_M = 1;
        #1 chk("prio_exit_vec", 32'(vec), 32'b0000110);
        cyc();
        clear_inputs();

        // Counter saturation at CNT_W=2.
        rst_pulse();
        set_load_use();
        for (int i = 0; i < 5; i++) begin
            #1 chk($sformatf("sat_stall%0d", i), 32'(Stall_F), 1);
            cyc();
        end
        chk("sat_stall_cnt", 32'(stall_cnt), 3);
        clear_inputs();

        // Reset in the middle of a memory wait.
        MemReq_M = 1; MemReady_M = 0;
        cyc();
        cyc();
        chk("mid_state_wait", 32'(dut.state), 32'(MEM_WAIT));
        #2 rst_n = 0;
        #1 chk("mid_rst_vec", 32'(vec), 32'h00);
        chk("mid_rst_state", 32'(dut.state), 32'(RUN));
        chk("mid_rst_err", 32'(mem_err), 0);
        chk("mid_rst_stall_cnt", 32'(stall_cnt), 0);
        clear_inputs();
        rst_n = 1;
        cyc();
        chk("mid_rst_after_err", 32'(mem_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
